mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous SRAM (1-cycle read latency, active-low CSN/WEN) between the core's instruction-fetch port and data port.
- Sits between the RISC_TOY IREQ/IADDR and DREQ/DRW/DADDR/DWDATA interfaces and the SRAM macro.
- Data accesses have priority. A starvation counter guarantees fetch progress.
- Also returns read data tagged to the requester, blocks out-of-range accesses and counts conflicts.

Parameters:
AW, 10, SRAM word-address width; word addresses at or above 2**AW are out of range
STARVE_LIMIT, 3, consecutive denied fetch cycles after which fetch wins (1..15)
CW, 16, width of the saturating conflict counter

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  asynchronous active-high reset
I_REQ  in  1  fetch request, held with I_ADDR until granted
I_ADDR  in  30  fetch word address
I_GNT  out  1  fetch accepted this cycle (combinational)
I_RVALID  out  1  I_RDATA valid this cycle
I_RDATA  out  32  fetched instruction
D_REQ  in  1  data request, held with D_RW/D_ADDR/D_WDATA until granted
D_RW  in  1  1=write, 0=read
D_ADDR  in  30  data word address
D_WDATA  in  32  write data
D_GNT  out  1  data accepted this cycle (combinational)
D_RVALID  out  1  D_RDATA valid this cycle (reads only)
D_RDATA  out  32  load data
ERR  out  1  one-cycle pulse: out-of-range access was granted last cycle
CONFLICT_CNT  out  CW  cycles in which both requests were present, saturating
M_CSN  out  1  SRAM chip select, active low
M_WEN  out  1  SRAM write enable, active low
M_A  out  AW  SRAM address
M_DI  out  32  SRAM write data
M_DOUT  in  32  SRAM read data, valid the cycle after a read is issued

Behaviour:
- Reset (RST=1, async): starve_cnt=0, rsel=NONE, I_RVALID=0, D_RVALID=0, ERR=0, CONFLICT_CNT=0.
- While RST=1: I_GNT=0, D_GNT=0, M_CSN=1, M_WEN=1, M_A=0, M_DI=0.
- Reset asserted mid-read drops the pending return; no RVALID follows.
- Winner selection is combinational, once per cycle:
  - Only one request present: that requester wins.
  - Both present and starve_cnt==STARVE_LIMIT: fetch wins.
  - Both present otherwise: data wins.
- Exactly one GNT is asserted per cycle with a request. No GNT when idle.
- starve_cnt, updated at the clock edge:
  - Fetch denied (I_REQ=1, I_GNT=0): increment, saturating at STARVE_LIMIT.
  - Fetch granted or I_REQ=0: clear to 0.
- SRAM command is driven combinationally from the winner:
  - M_A = winner address[AW-1:0].
  - M_WEN = 0 only for a granted in-range data write.
  - M_DI = D_WDATA.
  - M_CSN = 0 only if the winner's address bits [29:AW] are all zero.
- Out-of-range access:
  - Still granted, but M_CSN=1, so no SRAM access.
  - Next cycle: ERR=1. If the access was a read, the corresponding RVALID=1 with RDATA=0.
  - An out-of-range write produces ERR only.
- Read return pipeline:
  - Registered rsel in {NONE, IF, D, IF_OOR, D_OOR} records the granted read.
  - In the following cycle, the matching RVALID=1 and RDATA=M_DOUT (pass-through), or 0 for the OOR variants.
  - The non-selected RDATA is 0.
  - Granted writes set rsel=NONE.
- Throughput is one access per cycle. Back-to-back reads by either requester give consecutive RVALID pulses in grant order.
- A new grant in the same cycle as a return is legal.
- CONFLICT_CNT increments at each edge where I_REQ&D_REQ, saturating at 2**CW-1. It never wraps.
- Requests sampled with X or changing before GNT are a requester protocol violation; the arbiter does not check for them.

Test Plan:
- Reset with RST pulsed mid-cycle, no clock -> all outputs at reset values immediately; a pending read (rsel=IF) produces no I_RVALID afterwards.
- I_REQ only, I_ADDR=0x5, SRAM[5]=0xA5A5_0001 -> I_GNT=1 in cycle 0; I_RVALID=1 with I_RDATA=0xA5A50001 in cycle 1; D_GNT=0 throughout.
- D write D_ADDR=0x10, D_WDATA=0xDEADBEEF, then D read 0x10 next cycle -> M_WEN=0 in cycle 0; D_RVALID=1 with D_RDATA=0xDEADBEEF in cycle 2; no I_RVALID.
- I_REQ and D_REQ held high continuously, STARVE_LIMIT=3 -> grant pattern D,D,D,I repeating; CONFLICT_CNT=8 after 8 cycles.
- D read D_ADDR=0x400 (AW=10) -> D_GNT=1 with M_CSN=1; next cycle ERR=1, D_RVALID=1, D_RDATA=0; SRAM contents unchanged.
- CW=4, both requests held for 20 cycles -> CONFLICT_CNT stops at 15; starvation pattern unaffected.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one single-port synchronous SRAM between an instruction-fetch port
//   and a data port. Data wins conflicts unless fetch has been denied
//   STARVE_LIMIT consecutive cycles. Read data returns one cycle after the
//   grant, tagged to the requester. Out-of-range accesses are granted but
//   never reach the SRAM. They raise ERR and, for reads, return zero.
//   Cycles in which both requests are present are counted.
//
// Ports:
//   CLK, RST                      clock, asynchronous active-high reset
//   I_REQ, I_ADDR                 fetch request and word address
//   I_GNT                         fetch accepted this cycle (combinational)
//   I_RVALID, I_RDATA             fetch read return
//   D_REQ, D_RW, D_ADDR, D_WDATA  data request (D_RW=1 means write)
//   D_GNT                         data accepted this cycle (combinational)
//   D_RVALID, D_RDATA             data read return
//   ERR                           pulse: out-of-range access granted last cycle
//   CONFLICT_CNT                  saturating count of cycles with both requests
//   M_CSN, M_WEN, M_A, M_DI       SRAM command (active-low strobes)
//   M_DOUT                        SRAM read data, valid the cycle after a read
//
// AW must be in 1..30. STARVE_LIMIT must be in 1..15.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW           = 10,
  parameter int STARVE_LIMIT = 3,
  parameter int CW           = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          I_REQ,
  input  logic [29:0]   I_ADDR,
  output logic          I_GNT,
  output logic          I_RVALID,
  output logic [31:0]   I_RDATA,
  input  logic          D_REQ,
  input  logic          D_RW,
  input  logic [29:0]   D_ADDR,
  input  logic [31:0]   D_WDATA,
  output logic          D_GNT,
  output logic          D_RVALID,
  output logic [31:0]   D_RDATA,
  output logic          ERR,
  output logic [CW-1:0] CONFLICT_CNT,
  output logic          M_CSN,
  output logic          M_WEN,
  output logic [AW-1:0] M_A,
  output logic [31:0]   M_DI,
  input  logic [31:0]   M_DOUT
);

  localparam logic [3:0]    STARVE_MAX   = 4'(STARVE_LIMIT);
  localparam logic [CW-1:0] CONFLICT_MAX = {CW{1'b1}};

  // Pending read return: which requester owns next cycle's read data and
  // whether that data comes from the SRAM or is forced to zero.
  typedef enum logic [2:0] {
    RSEL_NONE   = 3'd0,
    RSEL_IF     = 3'd1,
    RSEL_D      = 3'd2,
    RSEL_IF_OOR = 3'd3,
    RSEL_D_OOR  = 3'd4
  } rsel_t;

  rsel_t          rsel_reg, rsel_next;
  logic [3:0]     starve_reg, starve_next;
  logic [CW-1:0]  conflict_reg, conflict_next;
  logic           err_reg, err_next;

  logic           i_in_range, d_in_range;
  logic           i_win, d_win, any_win, win_in_range;

  // An address is in range when every bit above the SRAM address is zero.
  // With AW=30 the whole word address maps onto the SRAM.
  generate
    if (AW >= 30) begin : g_full_range
      assign i_in_range = 1'b1;
      assign d_in_range = 1'b1;
    end else begin : g_part_range
      assign i_in_range = (I_ADDR[29:AW] == '0);
      assign d_in_range = (D_ADDR[29:AW] == '0);
    end
  endgenerate

  // Winner selection. Data wins unless fetch has hit the starvation limit
  // while both are requesting. Reset suppresses all grants.
  always_comb begin
    d_win = ~RST & D_REQ & ~(I_REQ & (starve_reg == STARVE_MAX));
    i_win = ~RST & I_REQ & ~d_win;
  end

  assign any_win      = i_win | d_win;
  assign win_in_range = d_win ? d_in_range : i_in_range;

  assign I_GNT = i_win;
  assign D_GNT = d_win;

  // SRAM command driven straight from the winner.
  assign M_CSN = ~(any_win & win_in_range);
  assign M_WEN = ~(d_win & D_RW & d_in_range);
  assign M_A   = d_win ? D_ADDR[AW-1:0] :
                 i_win ? I_ADDR[AW-1:0] : '0;
  assign M_DI  = RST ? 32'd0 : D_WDATA;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsel_reg     <= RSEL_NONE;
      starve_reg   <= 4'd0;
      conflict_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      rsel_reg     <= rsel_next;
      starve_reg   <= starve_next;
      conflict_reg <= conflict_next;
      err_reg      <= err_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    rsel_next = RSEL_NONE;
    if (i_win) begin
      rsel_next = i_in_range ? RSEL_IF : RSEL_IF_OOR;
    end else if (d_win && !D_RW) begin
      rsel_next = d_in_range ? RSEL_D : RSEL_D_OOR;
    end
  end

  always_comb begin
    starve_next = 4'd0;
    if (I_REQ && !i_win) begin
      starve_next = (starve_reg == STARVE_MAX) ? STARVE_MAX : starve_reg + 4'd1;
    end
  end

  always_comb begin
    conflict_next = conflict_reg;
    if (I_REQ && D_REQ && (conflict_reg != CONFLICT_MAX)) begin
      conflict_next = conflict_reg + 1'b1;
    end
  end

  assign err_next = any_win & ~win_in_range;

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    I_RVALID = 1'b0;
    I_RDATA  = 32'd0;
    D_RVALID = 1'b0;
    D_RDATA  = 32'd0;
    case (rsel_reg)
      RSEL_IF: begin
        I_RVALID = 1'b1;
        I_RDATA  = M_DOUT;
      end
      RSEL_IF_OOR: I_RVALID = 1'b1;
      RSEL_D: begin
        D_RVALID = 1'b1;
        D_RDATA  = M_DOUT;
      end
      RSEL_D_OOR: D_RVALID = 1'b1;
      default: ;
    endcase
  end

  assign ERR          = err_reg;
  assign CONFLICT_CNT = conflict_reg;

endmodule
